// File: rtl/kf_frame_sched.sv
// kf_frame_sched: frame scheduler in front of top_kf.
// Buffers measurement pairs in a small FIFO and launches one Kalman frame per
// measurement. It captures X_post when a frame completes and presents it on a
// single-slot valid/ready output. A frame that never reports done is trapped
// in a terminal error state.
module kf_frame_sched #(
    parameter int N       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         meas_valid,
    output logic         meas_ready,
    input  logic [N-1:0] meas_z00,
    input  logic [N-1:0] meas_z10,
    output logic         kf_start,
    output logic [N-1:0] kf_z00,
    output logic [N-1:0] kf_z10,
    input  logic         kf_done,
    input  logic [N-1:0] kf_x00,
    input  logic [N-1:0] kf_x10,
    output logic         est_valid,
    input  logic         est_ready,
    output logic [N-1:0] est_x00,
    output logic [N-1:0] est_x10,
    output logic [15:0]  frame_cnt,
    output logic         busy,
    output logic         err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_ZERO = TW'(0);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [N-1:0]  mem_z00_r [DEPTH];
    logic [N-1:0]  mem_z10_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic [TW-1:0] timer_r;
    logic          push_s;
    logic          pop_s;
    logic          done_s;
    logic          tmo_s;

    // FSM next-state decode; also flags the pop, frame completion and timeout events.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Single output slot: a new frame waits until the previous estimate is taken.
                if (enable && (count_r != CNT_ZERO) && !est_valid) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (kf_done) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_GAP;
                end else if (timer_r == TMR_LAST) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_GAP: begin
                // top_kf drops its running flag one cycle after done.
                state_nxt_s = ST_IDLE;
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        push_s      = meas_valid && meas_ready;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage: written on accepted push only, so a full FIFO is never overwritten.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_z00_r[wr_ptr_r] <= meas_z00;
            mem_z10_r[wr_ptr_r] <= meas_z10;
        end else begin
            mem_z00_r[wr_ptr_r] <= mem_z00_r[wr_ptr_r];
            mem_z10_r[wr_ptr_r] <= mem_z10_r[wr_ptr_r];
        end
    end

    // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // State register, frame watchdog timer and the registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            timer_r     <= TMR_ZERO;
            meas_ready  <= 1'b0;
            kf_start    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_LAUNCH) begin
                timer_r <= TMR_ZERO;
            end else if (state_r == ST_RUN) begin
                timer_r <= timer_r + TMR_ONE;
            end else begin
                timer_r <= timer_r;
            end
            // Outputs are derived from next-state values so they line up with the state.
            meas_ready  <= (count_nxt_s != CNT_FULL) && (state_nxt_s != ST_ERR);
            kf_start    <= (state_nxt_s == ST_LAUNCH);
            busy        <= (state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_RUN) ||
                           (state_nxt_s == ST_GAP);
            err_timeout <= err_timeout || tmo_s;
        end
    end

    // Measurement presented to top_kf: loaded at launch, held until the next launch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kf_z00 <= {N{1'b0}};
            kf_z10 <= {N{1'b0}};
        end else if (pop_s) begin
            kf_z00 <= mem_z00_r[rd_ptr_r];
            kf_z10 <= mem_z10_r[rd_ptr_r];
        end else begin
            kf_z00 <= kf_z00;
            kf_z10 <= kf_z10;
        end
    end

    // Estimate slot and completed-frame counter; kf_done outside RUN never reaches done_s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            est_valid <= 1'b0;
            est_x00   <= {N{1'b0}};
            est_x10   <= {N{1'b0}};
            frame_cnt <= 16'd0;
        end else begin
            if (done_s) begin
                est_valid <= 1'b1;
                est_x00   <= kf_x00;
                est_x10   <= kf_x10;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (est_valid && est_ready) begin
                est_valid <= 1'b0;
                est_x00   <= est_x00;
                est_x10   <= est_x10;
                frame_cnt <= frame_cnt;
            end else begin
                est_valid <= est_valid;
                est_x00   <= est_x00;
                est_x10   <= est_x10;
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_kf_frame_sched.sv
// Directed bench for kf_frame_sched with a behavioural top_kf model.
// Expected estimates go into a queue when a measurement is accepted.
// They are compared in order when the DUT hands an estimate over.
module tb_kf_frame_sched;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         meas_valid = 1'b0;
    logic         est_ready = 1'b0;
    logic [N-1:0] meas_z00 = 16'h0000;
    logic [N-1:0] meas_z10 = 16'h0000;
    logic [N-1:0] kf_x00 = 16'h0000;
    logic [N-1:0] kf_x10 = 16'h0000;
    logic         kf_done_m = 1'b0;
    logic         stray_done = 1'b0;
    logic         kf_done;
    logic         meas_ready, kf_start, est_valid, busy, err_timeout;
    logic [N-1:0] kf_z00, kf_z10, est_x00, est_x10;
    logic [15:0]  frame_cnt;

    assign kf_done = kf_done_m | stray_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int est_count = 0;
    int kf_cnt = 0;
    bit kf_run = 1'b0;
    bit kf_en = 1'b1;
    bit prev_start_ok = 1'b0;
    logic [31:0] exp_q[$];

    kf_frame_sched #(.N(N), .DEPTH(4), .TIMEOUT(40)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .meas_valid(meas_valid), .meas_ready(meas_ready),
        .meas_z00(meas_z00), .meas_z10(meas_z10),
        .kf_start(kf_start), .kf_z00(kf_z00), .kf_z10(kf_z10),
        .kf_done(kf_done), .kf_x00(kf_x00), .kf_x10(kf_x10),
        .est_valid(est_valid), .est_ready(est_ready),
        .est_x00(est_x00), .est_x10(est_x10),
        .frame_cnt(frame_cnt), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural top_kf result: a fixed offset on each component (0x0100,0xFF00 -> 0x0123,0x0045).
    function automatic logic [31:0] kf_model(input logic [15:0] a, input logic [15:0] b);
        return {a + 16'h0023, b + 16'h0145};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, output int acc);
        acc = -1;
        meas_z00 = a;
        meas_z10 = b;
        meas_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (meas_ready === 1'b1) begin
                @(posedge clk);
                #2;
                acc = cyc;
                break;
            end
        end
        meas_valid = 1'b0;
        chk("push_accept", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int i = 0;
        while (n_starts < target && i < budget) begin
            step(1);
            i++;
        end
        chk(tag, 32'(n_starts >= target), 32'd1);
    endtask

    task automatic wait_est_valid(input int budget, input string tag);
        int i = 0;
        while (est_valid !== 1'b1 && i < budget) begin
            step(1);
            i++;
        end
        chk(tag, 32'(est_valid), 32'd1);
    endtask

    task automatic wait_est_count(input int target, input int budget, input string tag);
        int i = 0;
        while (est_count < target && i < budget) begin
            step(1);
            i++;
        end
        chk(tag, 32'(est_count >= target), 32'd1);
    endtask

    // top_kf model: pulses done 34 cycles after it samples kf_start, checks launch spacing.
    initial begin : kf_model_proc
        forever begin
            @(posedge clk);
            #1;
            kf_done_m = 1'b0;
            if (rst_n !== 1'b1) begin
                kf_run = 1'b0;
                prev_start_ok = 1'b0;
            end else begin
                if (kf_run) begin
                    kf_cnt++;
                    if (kf_cnt == 34) begin
                        kf_done_m = 1'b1;
                        {kf_x00, kf_x10} = kf_model(kf_z00, kf_z10);
                        kf_run = 1'b0;
                        done_cyc = cyc;
                    end
                end
                if (kf_start === 1'b1) begin
                    if (prev_start_ok) chk("start_spacing", 32'((cyc - start_cyc) >= 36), 32'd1);
                    start_cyc = cyc;
                    prev_start_ok = 1'b1;
                    n_starts++;
                    kf_cnt = 0;
                    kf_run = kf_en;
                end
            end
        end
    end

    // Scoreboard: record accepted measurements, compare handed-over estimates in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && est_valid === 1'b1 && est_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("est_unexpected", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("est_x00", 32'(est_x00), 32'(e[31:16]));
                chk("est_x10", 32'(est_x10), 32'(e[15:0]));
            end
            est_count++;
        end
        if (rst_n === 1'b1 && meas_valid === 1'b1 && meas_ready === 1'b1) begin
            exp_q.push_back(kf_model(meas_z00, meas_z10));
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        int t, s0, e0, h, lc, acc;
        bit seen;

        // Reset state
        step(3);
        chk("rst_meas_ready", 32'(meas_ready), 32'd0);
        chk("rst_kf_start", 32'(kf_start), 32'd0);
        chk("rst_est_valid", 32'(est_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_kf_z00", 32'(kf_z00), 32'd0);
        chk("rst_est_x00", 32'(est_x00), 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_meas_ready", 32'(meas_ready), 32'd1);

        // 1: single frame; kf_start is high in the cycle top_kf samples at edge t+2
        enable = 1'b1;
        est_ready = 1'b0;
        push(16'h0100, 16'hFF00, t);
        wait_starts(1, 5, "t1_start_seen");
        chk("t1_start_cycle", 32'(start_cyc), 32'(t + 1));
        chk("t1_kf_z00", 32'(kf_z00), 32'h0100);
        wait_est_valid(60, "t1_est_valid");
        chk("t1_est_latency", 32'(cyc), 32'(done_cyc + 1));
        chk("t1_est_x00", 32'(est_x00), 32'h0123);
        chk("t1_est_x10", 32'(est_x10), 32'h0045);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        step(1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_est_hold", 32'(est_valid), 32'd1);
        est_ready = 1'b1;
        step(1);
        est_ready = 1'b0;
        chk("t1_est_cleared", 32'(est_valid), 32'd0);

        // 2: burst of five into a four-deep FIFO
        enable = 1'b0;
        est_ready = 1'b1;
        s0 = n_starts;
        e0 = est_count;
        for (int i = 0; i < 4; i++) begin
            push(16'(16'h1000 + 16'(i) * 16'h0111), 16'(16'h8000 - 16'(i) * 16'h0203), acc);
        end
        chk("t2_full_ready", 32'(meas_ready), 32'd0);
        step(3);
        chk("t2_full_hold", 32'(meas_ready), 32'd0);
        chk("t2_no_start_disabled", 32'(n_starts), 32'(s0));
        enable = 1'b1;
        push(16'h2222, 16'h3333, acc);
        chk("t2_fifth_after_pop", 32'(acc), 32'(start_cyc + 1));
        wait_est_count(e0 + 5, 400, "t2_five_estimates");
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd6);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: backpressure holds frame 2 until the estimate is taken
        est_ready = 1'b0;
        s0 = n_starts;
        e0 = est_count;
        push(16'h0A0A, 16'h0B0B, acc);
        push(16'h0C0C, 16'h0D0D, acc);
        wait_starts(s0 + 1, 10, "t3_first_start");
        wait_est_valid(60, "t3_est_valid");
        step(20);
        chk("t3_no_second_start", 32'(n_starts), 32'(s0 + 1));
        chk("t3_est_still_valid", 32'(est_valid), 32'd1);
        est_ready = 1'b1;
        h = cyc + 1;
        step(1);
        est_ready = 1'b0;
        wait_starts(s0 + 2, 5, "t3_second_start");
        chk("t3_start_after_accept", 32'(start_cyc), 32'(h + 1));
        est_ready = 1'b1;
        wait_est_count(e0 + 2, 60, "t3_two_estimates");
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd8);

        // 4: hung frame trips the watchdog, stays in error until reset
        kf_en = 1'b0;
        s0 = n_starts;
        push(16'h5555, 16'hAAAA, acc);
        wait_starts(s0 + 1, 5, "t4_start");
        lc = start_cyc;
        wait_cyc(lc + 40);
        chk("t4_err_not_yet", 32'(err_timeout), 32'd0);
        step(1);
        chk("t4_err_set", 32'(err_timeout), 32'd1);
        chk("t4_meas_ready", 32'(meas_ready), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        meas_z00 = 16'h7777;
        meas_valid = 1'b1;
        step(5);
        meas_valid = 1'b0;
        chk("t4_no_start", 32'(n_starts), 32'(s0 + 1));
        chk("t4_err_sticky", 32'(err_timeout), 32'd1);
        chk("t4_ready_stuck", 32'(meas_ready), 32'd0);
        rst_n = 1'b0;
        step(1);
        exp_q.delete();
        chk("t4_err_cleared", 32'(err_timeout), 32'd0);
        chk("t4_frame_cnt_rst", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        kf_en = 1'b1;
        step(1);
        chk("t4_ready_back", 32'(meas_ready), 32'd1);

        // 5: reset in the middle of RUN abandons the frame
        est_ready = 1'b1;
        s0 = n_starts;
        e0 = est_count;
        push(16'h1234, 16'h5678, acc);
        wait_starts(s0 + 1, 5, "t5_start");
        wait_cyc(start_cyc + 15);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_est_rst", 32'(est_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (est_valid === 1'b1) seen = 1'b1;
        end
        chk("t5_no_est", 32'(seen), 32'd0);
        chk("t5_fifo_empty", 32'(n_starts), 32'(s0 + 1));
        push(16'h4321, 16'h8765, acc);
        wait_est_count(e0 + 1, 60, "t5_fresh_est");
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

        // 6: enable low holds IDLE; stray kf_done in IDLE is ignored
        enable = 1'b0;
        s0 = n_starts;
        e0 = est_count;
        push(16'h0F0F, 16'hF0F0, acc);
        step(10);
        chk("t6_no_start", 32'(n_starts), 32'(s0));
        chk("t6_busy", 32'(busy), 32'd0);
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        step(1);
        chk("t6_stray_cnt", 32'(frame_cnt), 32'd1);
        chk("t6_stray_est", 32'(est_valid), 32'd0);
        enable = 1'b1;
        wait_est_count(e0 + 1, 60, "t6_est");
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
